// File: rtl/seq_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : seq_sched_pkg
// Description : State encodings and pattern constant shared by the
//               scheduler and its bit-serial "1001" detector.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
package seq_sched_pkg;

    typedef enum logic [2:0] {
        DET_START = 3'd0,
        DET_S1    = 3'd1,
        DET_S10   = 3'd2,
        DET_S100  = 3'd3,
        DET_S1001 = 3'd4
    } det_state_t;

    typedef enum logic [1:0] {
        SCH_IDLE   = 2'd0,
        SCH_SHIFT  = 2'd1,
        SCH_SETTLE = 2'd2,
        SCH_RESULT = 2'd3
    } sch_state_t;

    localparam logic [3:0] PATTERN = 4'b1001;

endpackage
`default_nettype wire

// File: rtl/seq_1001_det.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : seq_1001_det
// Description : Moore detector for the serial pattern "1001" with sync clear.
//               SEQ_SCHED_OVERLAP_EN selects overlapping match counting.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module seq_1001_det
    import seq_sched_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic x,
    output logic y
);

    det_state_t r_state;
    det_state_t w_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DET_START;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = DET_START;
        if (!clr) begin
            case (r_state)
                DET_START: w_next = x ? DET_S1 : DET_START;
                DET_S1:    w_next = x ? DET_S1 : DET_S10;
                DET_S10:   w_next = x ? DET_S1 : DET_S100;
                DET_S100:  w_next = x ? DET_S1001 : DET_START;
`ifdef SEQ_SCHED_OVERLAP_EN
                // The trailing 1 of a match doubles as the prefix of the next one.
                DET_S1001: w_next = x ? DET_S1 : DET_S10;
`else
                DET_S1001: w_next = x ? DET_S1 : DET_START;
`endif
                default:   w_next = DET_START;
            endcase
        end
    end

    assign y = (r_state == DET_S1001);

endmodule
`default_nettype wire

// File: rtl/seq_det_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : seq_det_scheduler
// Description : Round-robin arbiter feeding granted words MSB-first into a
//               shared "1001" detector; returns match count and channel.
//               SEQ_SCHED_OVERLAP_EN (in seq_1001_det) enables overlap mode.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module seq_det_scheduler
    import seq_sched_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int CW  = 4,
    parameter int CHW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*DW-1:0] req_data,
    output logic [NCH-1:0]    req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CHW-1:0]    res_ch,
    output logic [CW-1:0]     res_count,
    output logic              busy
);

    localparam int BCW = (DW > 1) ? $clog2(DW) : 1;

    sch_state_t       r_state;
    sch_state_t       w_next;
    logic [CHW-1:0]   r_ptr;
    logic [CHW-1:0]   r_ch;
    logic [DW-1:0]    r_shreg;
    logic [BCW-1:0]   r_bit_cnt;
    logic [CW-1:0]    r_count;
    logic [CHW-1:0]   w_grant_ch;
    logic [CHW-1:0]   w_idx;
    logic             w_grant_any;
    logic             w_det_clr;
    logic             w_det_y;
    logic             w_bit_last;
    logic             w_count_inc;

    // Scan from the highest offset down so the closest valid channel wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_ch  = '0;
        w_idx       = '0;
        for (int off = NCH - 1; off >= 0; off--) begin
            w_idx = CHW'((int'(r_ptr) + off) % NCH);
            if (req_valid[w_idx]) begin
                w_grant_any = 1'b1;
                w_grant_ch  = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SCH_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        w_det_clr = 1'b0;
        case (r_state)
            SCH_IDLE: begin
                if (w_grant_any) begin
                    req_ready[w_grant_ch] = 1'b1;
                    w_det_clr             = 1'b1;
                    w_next                = SCH_SHIFT;
                end
            end
            SCH_SHIFT:  if (w_bit_last) w_next = SCH_SETTLE;
            SCH_SETTLE: w_next = SCH_RESULT;
            SCH_RESULT: if (res_ready) w_next = SCH_IDLE;
            default:    w_next = SCH_IDLE;
        endcase
    end

    assign w_bit_last  = (r_bit_cnt == BCW'(DW - 1));
    assign w_count_inc = w_det_y && (r_count != '1) &&
                         ((r_state == SCH_SHIFT) || (r_state == SCH_SETTLE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr     <= '0;
            r_ch      <= '0;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_count   <= '0;
        end else begin
            if ((r_state == SCH_IDLE) && w_grant_any) begin
                r_shreg   <= req_data[w_grant_ch*DW +: DW];
                r_ch      <= w_grant_ch;
                r_ptr     <= CHW'((int'(w_grant_ch) + 1) % NCH);
                r_bit_cnt <= '0;
                r_count   <= '0;
            end else begin
                if (r_state == SCH_SHIFT) begin
                    r_shreg   <= r_shreg << 1;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_count_inc) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    seq_1001_det u_det (
        .clk   (clk),
        .reset (reset),
        .clr   (w_det_clr),
        .x     (r_shreg[DW-1]),
        .y     (w_det_y)
    );

    assign res_valid = (r_state == SCH_RESULT);
    assign busy      = (r_state != SCH_IDLE);
    assign res_ch    = r_ch;
    assign res_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_det_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_seq_det_scheduler
// Description : Randomized and directed self-checking bench for
//               seq_det_scheduler against a pattern-scanning reference.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_seq_det_scheduler;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int CHW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    req_valid;
    logic [NCH*DW-1:0] req_data;
    logic [NCH-1:0]    req_ready;
    logic              res_valid;
    logic              res_ready;
    logic [CHW-1:0]    res_ch;
    logic [CW-1:0]     res_count;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int m_ptr = 0;

    always #5 clk = ~clk;

    seq_det_scheduler #(.NCH(NCH), .DW(DW), .CW(CW), .CHW(CHW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_ch    (res_ch),
        .res_count (res_count),
        .busy      (busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Occurrences of 1001 in the MSB-first bit stream of one word.
    function automatic int ref_count(input logic [DW-1:0] w);
        int cnt = 0;
        int i   = 0;
        while (i <= DW - 4) begin
            if (w[DW-1-i -: 4] == 4'b1001) begin
                cnt++;
`ifdef SEQ_SCHED_OVERLAP_EN
                i += 1;
`else
                i += 4;
`endif
            end else begin
                i++;
            end
        end
        if (cnt > (2**CW) - 1) cnt = (2**CW) - 1;
        return cnt;
    endfunction

    function automatic int ref_pick(input logic [NCH-1:0] v);
        for (int off = 0; off < NCH; off++) begin
            if (v[(m_ptr + off) % NCH]) return (m_ptr + off) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [NCH*DW-1:0] mk(input int ch, input logic [DW-1:0] w);
        logic [NCH*DW-1:0] r;
        r = NCH*DW'($urandom);
        r[ch*DW +: DW] = w;
        return r;
    endfunction

    task automatic do_frame(input logic [NCH-1:0] v, input logic [NCH*DW-1:0] d, input int hold);
        int ch;
        int cnt;
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        res_ready = 1'b0;
        #1;
        ch  = ref_pick(v);
        cnt = ref_count(d[ch*DW +: DW]);
        check("grant", int'(req_ready), 1 << ch);
        check("idle_busy", int'(busy), 0);
        m_ptr = (ch + 1) % NCH;
        for (int c = 1; c <= DW + 2; c++) begin
            @(negedge clk);
            #1;
            if (c < DW + 2) begin
                check("early_valid", int'(res_valid), 0);
                check("frame_busy", int'(busy), 1);
            end
            check("no_ready", int'(req_ready), 0);
        end
        check("res_valid", int'(res_valid), 1);
        check("res_ch", int'(res_ch), ch);
        check("res_count", int'(res_count), cnt);
        for (int s = 0; s < hold; s++) begin
            @(negedge clk);
            #1;
            check("hold_valid", int'(res_valid), 1);
            check("hold_ch", int'(res_ch), ch);
            check("hold_count", int'(res_count), cnt);
            check("hold_ready", int'(req_ready), 0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("done_valid", int'(res_valid), 0);
        check("done_busy", int'(busy), 0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_valid", int'(res_valid), 0);
        check("rst_ch", int'(res_ch), 0);
        check("rst_count", int'(res_count), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;

        do_frame(4'b0001, mk(0, 8'b10010010), 0);
        do_frame(4'b1010, NCH*DW'($urandom), 0);
        do_frame(4'b1010, NCH*DW'($urandom), 0);
        do_frame(4'b0011, NCH*DW'($urandom), 0);
        do_frame(4'b0100, mk(2, 8'b10011001), 0);
        do_frame(4'b0100, mk(2, 8'b00000000), 0);
        do_frame(4'b0110, NCH*DW'($urandom), 5);
        do_frame(4'b0001, mk(0, 8'b00000001), 0);
        do_frame(4'b0001, mk(0, 8'b00100000), 0);

        // Abort a frame mid-shift, then prove the pointer returned to 0.
        @(negedge clk);
        req_valid = 4'b0100;
        req_data  = mk(2, 8'hFF);
        repeat (3) @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        #1;
        check("abort_ready", int'(req_ready), 0);
        check("abort_valid", int'(res_valid), 0);
        check("abort_ch", int'(res_ch), 0);
        check("abort_count", int'(res_count), 0);
        check("abort_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        m_ptr = 0;
        do_frame(4'b1001, mk(0, 8'b10010000), 0);

        repeat (40) begin
            do_frame(NCH'($urandom_range(1, (2**NCH) - 1)), NCH*DW'($urandom),
                     int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
